pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the generalised successor of the fixed IF/ID latch. It carries an opaque payload plus interrupt sideband (flag and number) between two pipeline stages. It adds valid/ready handshaking, a 2-entry skid buffer that keeps full throughput under downstream backpressure, a stall (lock) input, and a flush with bubble insertion. It is instantiated at IF/ID, ID/EX and EX/MEM boundaries.

Parameters:
DATA_W, 96, payload width in bits (e.g. PC_plus, instruction, EPC).
INT_W, 2, interrupt-number width.
BUBBLE, {DATA_W{1'b0}}, payload value presented when empty or after flush (NOP encoding).
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register, in_ready = ~full | out_ready.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
lock  in  1  stall; freezes all state, blocks both handshakes.
flush  in  1  discard all held beats; wins over everything except reset.
in_valid  in  1  upstream beat present.
in_ready  out  1  stage can accept a beat this cycle.
in_data  in  DATA_W  upstream payload.
in_int  in  1  interrupt-trigger flag accompanying the beat.
in_int_num  in  INT_W  interrupt number accompanying the beat.
out_valid  out  1  head beat present.
out_ready  in  1  downstream accepts head beat.
out_data  out  DATA_W  head payload; BUBBLE when out_valid=0.
out_int  out  1  head interrupt flag; 0 when out_valid=0.
out_int_num  out  INT_W  head interrupt number; 0 when out_valid=0.
count  out  2  occupancy, 0..2.

Behaviour:
- Reset (rst=0, async): state EMPTY, count=0, out_valid=0, out_data=BUBBLE, out_int=0, out_int_num=0, in_ready=0 while asserted. Release is sampled synchronously; in_ready goes high in the first cycle after release.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~lock.
- in_ready = ~lock & ~flush & (count<2) when SKID_EN=1. It depends only on registered state and lock/flush, with no out_ready combinational path.
- States (SKID_EN=1): EMPTY (count 0), HEAD (1, main reg), FULL (2, main + skid reg).
  - EMPTY: in_fire -> HEAD. Data is visible at out_* the next cycle (latency 1).
  - HEAD: in_fire & ~out_fire -> FULL (beat into skid). ~in_fire & out_fire -> EMPTY. Both or neither -> HEAD (main reloads on both).
  - FULL: out_fire -> HEAD (skid moves to main, skid cleared). in_ready=0.
- Ordering is strictly FIFO and no beat is duplicated or lost. Interrupt fields travel atomically with their payload.
- lock=1: no state change, outputs hold their values, in_ready=0, out_fire suppressed even when out_ready=1.
- flush=1: next edge -> EMPTY, both registers loaded with BUBBLE/0, count=0. Any concurrent in_valid beat is dropped (in_ready=0 that cycle). flush overrides lock.
- Reset mid-operation: immediate clear, same as reset values. No partial beat survives.
- SKID_EN=0: states EMPTY/HEAD only. in_ready = ~lock & ~flush & (~out_valid | out_ready) (combinational pass-through of ready). count never exceeds 1.
- out_* come straight from the main register, with no combinational path from in_*.

Decomposition:
- Shared pipeline package: state encoding (ST_EMPTY=2'd0, ST_HEAD=2'd1, ST_FULL=2'd2) and the default NOP/BUBBLE constant.
- The existing generic register module is reused for the main and skid storage (width DATA_W+1+INT_W, write-enable per state logic).
- No further sub-module is needed.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then release -> out_valid=0, out_data=BUBBLE, count=0; in_ready=1 on the cycle after release.
- Streaming: in_valid=1 for 8 beats data=1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, count stays 1.
- Backpressure: stream 1..4, out_ready=0 from cycle 2 -> count=2, in_ready=0, out_data=1 held. Release out_ready -> 1,2,3,4 delivered in order, none lost.
- Interrupt sideband: beat 0x5 with in_int=1, in_int_num=2'b10 queued behind a stalled beat -> out_int=1, out_int_num=2 appear exactly with data 0x5, and 0 otherwise.
- lock vs flush: FULL with lock=1, out_ready=1 for 3 cycles -> no change. Then flush=1 with lock=1 and in_valid=1 -> next cycle count=0, out_valid=0, out_data=BUBBLE, input beat dropped.
- SKID_EN=0 variant: out_ready toggles 1,0,1 with continuous input -> in_ready follows out_ready when full, count≤1, order preserved.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: occupancy state encoding and the default NOP payload.
package pipe_stage_reg_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned PSR_DATA_W = 96;
  localparam int unsigned PSR_INT_W  = 2;
  localparam logic [PSR_DATA_W-1:0] NOP_BUBBLE = '0;
endpackage

// File: rtl/pipe_stage_reg_dff.sv
// Generic enable register with asynchronous active-low reset to a parameterised value.
module pipe_stage_reg_dff #(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= RST_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer, stall (lock) and flush.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned        DATA_W  = PSR_DATA_W,
  parameter int unsigned        INT_W   = PSR_INT_W,
  parameter logic [DATA_W-1:0]  BUBBLE  = DATA_W'(NOP_BUBBLE),
  parameter bit                 SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_int,
  input  logic [INT_W-1:0]  in_int_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_int,
  output logic [INT_W-1:0]  out_int_num,
  output logic [1:0]        count
);
  localparam int unsigned   BW         = DATA_W + 1 + INT_W;
  localparam logic [BW-1:0] EMPTY_BEAT = {BUBBLE, 1'b0, {INT_W{1'b0}}};

  state_e        state_q, state_d;
  logic          alive_q;
  logic [BW-1:0] in_beat, main_q, main_d, skid_q, skid_d;
  logic          main_en, skid_en;
  logic          in_fire, out_fire;

  assign in_beat   = {in_data, in_int, in_int_num};
  assign out_valid = (state_q != ST_EMPTY);
  assign {out_data, out_int, out_int_num} = main_q;
  assign count     = state_q;

  // alive_q holds in_ready low until the first edge after reset release.
  generate
    if (SKID_EN) begin : g_skid_rdy
      assign in_ready = alive_q & ~lock & ~flush & (state_q != ST_FULL);
    end else begin : g_pass_rdy
      assign in_ready = alive_q & ~lock & ~flush & (~out_valid | out_ready);
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready & ~lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = in_beat;
    skid_en = 1'b0;
    skid_d  = in_beat;
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b1;
      main_d  = EMPTY_BEAT;
      skid_en = 1'b1;
      skid_d  = EMPTY_BEAT;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_HEAD;
          main_en = 1'b1;
        end
        ST_HEAD: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (in_fire && out_fire) begin
            main_en = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_en = 1'b1;
            main_d  = EMPTY_BEAT;
          end
        end
        ST_FULL: if (out_fire) begin
          state_d = ST_HEAD;
          main_en = 1'b1;
          main_d  = skid_q;
          skid_en = 1'b1;
          skid_d  = EMPTY_BEAT;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_stage_reg_dff #(.W(BW), .RST_VAL(EMPTY_BEAT)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  // Without a skid buffer the skid register is never written and folds to a constant.
  pipe_stage_reg_dff #(.W(BW), .RST_VAL(EMPTY_BEAT)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en & SKID_EN),
    .d   (skid_d),
    .q   (skid_q)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and pass-through variants share stimulus, checked by a queue model.
module tb_pipe_stage_reg;
  localparam logic [15:0] BUB1 = 16'hBEEF;
  localparam logic [15:0] BUB0 = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, lock, flush, in_valid, out_ready, in_int;
  logic [15:0] in_data;
  logic [1:0]  in_int_num;

  logic        ir1, ov1, oi1, ir0, ov0, oi0;
  logic [15:0] od1, od0;
  logic [1:0]  on1, on0, cnt1, cnt0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .INT_W(2), .BUBBLE(BUB1), .SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .lock(lock), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_int(in_int), .in_int_num(in_int_num),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_int(oi1), .out_int_num(on1),
    .count(cnt1)
  );

  pipe_stage_reg #(.DATA_W(16), .INT_W(2), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .lock(lock), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_int(in_int), .in_int_num(in_int_num),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_int(oi0), .out_int_num(on0),
    .count(cnt0)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        i;
    logic [1:0]  n;
  } beat_t;

  typedef struct {
    logic        lk, fl, iv, rd;
    logic [15:0] d;
    logic        it;
    logic [1:0]  n;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_oi;
    logic [1:0]  e_on;
    logic [1:0]  e_cnt;
    logic        e_ir;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  beat_t q1[$];
  beat_t q0[$];
  bit    alive = 1'b0;
  vec_t  tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Stage accepts when alive, not stalled/flushed, and there is room (or, without skid, room after this cycle's pop).
  function automatic logic exp_ir(input bit skid, input int sz);
    if (!alive || lock || flush) return 1'b0;
    if (skid) return (sz < 2);
    return (sz == 0) || out_ready;
  endfunction

  task automatic check_model();
    beat_t h1, h0;
    h1 = '0; h1.d = BUB1;
    h0 = '0; h0.d = BUB0;
    if (q1.size() > 0) h1 = q1[0];
    if (q0.size() > 0) h0 = q0[0];
    chk("s1.in_ready",  {31'd0, ir1}, {31'd0, exp_ir(1'b1, q1.size())});
    chk("s1.out_valid", {31'd0, ov1}, {31'd0, q1.size() > 0});
    chk("s1.out_data",  {16'd0, od1}, {16'd0, h1.d});
    chk("s1.out_int",   {31'd0, oi1}, {31'd0, h1.i});
    chk("s1.out_num",   {30'd0, on1}, {30'd0, h1.n});
    chk("s1.count",     {30'd0, cnt1}, q1.size());
    chk("s0.in_ready",  {31'd0, ir0}, {31'd0, exp_ir(1'b0, q0.size())});
    chk("s0.out_valid", {31'd0, ov0}, {31'd0, q0.size() > 0});
    chk("s0.out_data",  {16'd0, od0}, {16'd0, h0.d});
    chk("s0.out_int",   {31'd0, oi0}, {31'd0, h0.i});
    chk("s0.out_num",   {30'd0, on0}, {30'd0, h0.n});
    chk("s0.count",     {30'd0, cnt0}, q0.size());
  endtask

  task automatic update_model();
    logic  a1, a0;
    beat_t b;
    a1 = exp_ir(1'b1, q1.size());
    a0 = exp_ir(1'b0, q0.size());
    b  = {in_data, in_int, in_int_num};
    if (!rst) begin
      q1.delete(); q0.delete(); alive = 1'b0;
    end else if (flush) begin
      q1.delete(); q0.delete(); alive = 1'b1;
    end else begin
      if (!lock && out_ready && q1.size() > 0) void'(q1.pop_front());
      if (!lock && out_ready && q0.size() > 0) void'(q0.pop_front());
      if (in_valid && a1) q1.push_back(b);
      if (in_valid && a0) q0.push_back(b);
      alive = 1'b1;
    end
  endtask

  // Inputs are applied one step after the rising edge; outputs are sampled one step later.
  task automatic tick();
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lk, input logic fl, input logic iv, input logic rd,
                       input logic [15:0] d, input logic it, input logic [1:0] n);
    lock = lk; flush = fl; in_valid = iv; out_ready = rd;
    in_data = d; in_int = it; in_int_num = n;
  endtask

  function automatic vec_t mk(input logic lk, input logic fl, input logic iv, input logic rd,
                              input logic [15:0] d, input logic it, input logic [1:0] n,
                              input logic e_ov, input logic [15:0] e_od, input logic e_oi,
                              input logic [1:0] e_on, input logic [1:0] e_cnt, input logic e_ir);
    vec_t v;
    v.lk = lk; v.fl = fl; v.iv = iv; v.rd = rd; v.d = d; v.it = it; v.n = n;
    v.e_ov = e_ov; v.e_od = e_od; v.e_oi = e_oi; v.e_on = e_on; v.e_cnt = e_cnt; v.e_ir = e_ir;
    return v;
  endfunction

  initial begin
    //            lk fl iv rd  d     it n    ov od    oi on cnt ir
    tbl[0]  = mk(0, 0, 1, 1, 16'd1, 0, 0,  0, BUB1, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 1, 0, 16'd2, 0, 0,  1, 16'd1, 0, 0, 1, 1);
    tbl[2]  = mk(0, 0, 1, 0, 16'd3, 0, 0,  1, 16'd1, 0, 0, 2, 0);
    tbl[3]  = mk(0, 0, 1, 1, 16'd3, 0, 0,  1, 16'd1, 0, 0, 2, 0);
    tbl[4]  = mk(0, 0, 1, 1, 16'd3, 0, 0,  1, 16'd2, 0, 0, 1, 1);
    tbl[5]  = mk(0, 0, 1, 0, 16'd4, 0, 0,  1, 16'd3, 0, 0, 1, 1);
    tbl[6]  = mk(0, 0, 1, 0, 16'd5, 1, 2,  1, 16'd3, 0, 0, 2, 0);
    tbl[7]  = mk(0, 0, 1, 1, 16'd5, 1, 2,  1, 16'd3, 0, 0, 2, 0);
    tbl[8]  = mk(0, 0, 1, 0, 16'd5, 1, 2,  1, 16'd4, 0, 0, 1, 1);
    tbl[9]  = mk(0, 0, 0, 1, 16'd0, 0, 0,  1, 16'd4, 0, 0, 2, 0);
    tbl[10] = mk(0, 0, 0, 0, 16'd0, 0, 0,  1, 16'd5, 1, 2, 1, 1);
    tbl[11] = mk(1, 0, 1, 1, 16'd6, 0, 0,  1, 16'd5, 1, 2, 1, 0);
    tbl[12] = mk(0, 0, 1, 0, 16'd6, 0, 0,  1, 16'd5, 1, 2, 1, 1);
    tbl[13] = mk(1, 0, 1, 1, 16'd7, 0, 0,  1, 16'd5, 1, 2, 2, 0);
    tbl[14] = mk(1, 0, 1, 1, 16'd7, 0, 0,  1, 16'd5, 1, 2, 2, 0);
    tbl[15] = mk(1, 0, 1, 1, 16'd7, 0, 0,  1, 16'd5, 1, 2, 2, 0);
    tbl[16] = mk(1, 1, 1, 1, 16'd7, 0, 0,  1, 16'd5, 1, 2, 2, 0);
    tbl[17] = mk(0, 0, 1, 1, 16'd8, 0, 0,  0, BUB1, 0, 0, 0, 1);
    tbl[18] = mk(0, 1, 1, 0, 16'd9, 0, 0,  1, 16'd8, 0, 0, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 16'd0, 0, 0,  0, BUB1, 0, 0, 0, 1);

    rst = 1'b0;
    drive(0, 0, 0, 0, 16'd0, 0, 0);
    @(posedge clk); #1;

    repeat (3) begin
      #1;
      chk("rst.in_ready",  {31'd0, ir1}, 32'd0);
      chk("rst.out_valid", {31'd0, ov1}, 32'd0);
      chk("rst.out_data",  {16'd0, od1}, {16'd0, BUB1});
      chk("rst.count",     {30'd0, cnt1}, 32'd0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("rel.in_ready_pre", {31'd0, ir1}, 32'd0);
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].lk, tbl[i].fl, tbl[i].iv, tbl[i].rd, tbl[i].d, tbl[i].it, tbl[i].n);
      #1;
      chk($sformatf("tbl%0d.out_valid", i), {31'd0, ov1}, {31'd0, tbl[i].e_ov});
      chk($sformatf("tbl%0d.out_data", i),  {16'd0, od1}, {16'd0, tbl[i].e_od});
      chk($sformatf("tbl%0d.out_int", i),   {31'd0, oi1}, {31'd0, tbl[i].e_oi});
      chk($sformatf("tbl%0d.out_num", i),   {30'd0, on1}, {30'd0, tbl[i].e_on});
      chk($sformatf("tbl%0d.count", i),     {30'd0, cnt1}, {30'd0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d.in_ready", i),  {31'd0, ir1}, {31'd0, tbl[i].e_ir});
      tick();
    end

    // Streaming with no backpressure: 1-cycle latency, occupancy stays at 1.
    for (int i = 0; i <= 8; i++) begin
      drive(0, 0, (i < 8), 1, 16'(i + 1), 0, 0);
      #1;
      chk($sformatf("strm%0d.out_data", i), {16'd0, od1}, (i == 0) ? {16'd0, BUB1} : i);
      chk($sformatf("strm%0d.count", i),    {30'd0, cnt1}, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end

    // Pass-through variant: continuous input, out_ready toggling.
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, (i % 2 == 0), 16'(16'h100 + i), 0, 0);
      #1;
      chk($sformatf("nsk%0d.count_le1", i), {31'd0, (cnt0 > 2'd1)}, 32'd0);
      if (ov0) chk($sformatf("nsk%0d.in_ready", i), {31'd0, ir0}, {31'd0, out_ready});
      tick();
    end
    drive(0, 0, 0, 1, 16'd0, 0, 0);
    #1; tick();
    #1; tick();

    // Reset while holding beats clears asynchronously.
    drive(0, 0, 1, 0, 16'h0A0A, 1, 3);
    #1; tick();
    #1; tick();
    rst = 1'b0;
    q1.delete(); q0.delete(); alive = 1'b0;
    #1;
    chk("midrst.out_valid", {31'd0, ov1}, 32'd0);
    chk("midrst.out_data",  {16'd0, od1}, {16'd0, BUB1});
    chk("midrst.out_int",   {31'd0, oi1}, 32'd0);
    chk("midrst.count",     {30'd0, cnt1}, 32'd0);
    tick();
    #1; tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 16'd0, 0, 0);
    #1; tick();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9) == 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
            $urandom_range(9) < 6, 16'($urandom), 1'($urandom_range(1)), 2'($urandom_range(3)));
      #1;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
